// File: rtl/sensor_checker_pkg.sv
// Shared types and constants for the sensor frame checker.
package sensor_checker_pkg;

  // Checker FSM states.
  //   S_SYNC   : no idle phase known; idle words are not judged.
  //   S_IDLE_A : last idle word was IDLE_0 (or a frame just ended and either byte may follow).
  //   S_IDLE_B : last idle word was IDLE_1.
  //   S_FRAME  : inside a frame, between SOF and EOF.
  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_IDLE_A = 2'd1,
    S_IDLE_B = 2'd2,
    S_FRAME  = 2'd3
  } state_e;

  // Saturation ceiling shared by every counter.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit saturating event counter; clear wins over a same-cycle increment.
module sat_counter32
  import sensor_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] value
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: clear first, otherwise step unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

endmodule

// File: rtl/sensor_frame_checker.sv
// Passive checker for the sensor-emulator LVDS stream: idle alternation,
// pattern replication/constancy, frame length and expected-pattern compare.
//
// Pipeline: stage 1 registers the bus and markers, stage 2 registers the
// compare results, stage 3 runs the FSM and the counters, so a counter moves
// 3 cycles after the offending bus cycle.
//
// EXPECT stream handshake: a transfer happens on a cycle where EXPECT_TVALID
// and EXPECT_TREADY are both high. EXPECT_TREADY is raised only while a SOF
// word sits in stage 3 and EXPECT_TVALID is high, so exactly one expected
// pattern is consumed per started frame; with EXPECT_TVALID low the frame is
// simply not pattern-checked.
module sensor_frame_checker
  import sensor_checker_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32,
  parameter int LVDS_WIDTH    = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     CLEAR,
  input  logic [31:0]              CYCLES_PER_FRAME,
  input  logic [7:0]               IDLE_0,
  input  logic [7:0]               IDLE_1,
  input  logic [LVDS_WIDTH-1:0]    LVDS,
  input  logic                     SOF,
  input  logic                     EOF,
  input  logic [PATTERN_WIDTH-1:0] EXPECT_TDATA,
  input  logic                     EXPECT_TVALID,
  output logic                     EXPECT_TREADY,
  output logic [31:0]              FRAME_COUNT,
  output logic [31:0]              ERR_IDLE,
  output logic [31:0]              ERR_REPLICA,
  output logic [31:0]              ERR_LENGTH,
  output logic [31:0]              ERR_PATTERN,
  output logic [31:0]              ERR_PROTO,
  output logic                     ERROR
);

  localparam int PATTERN_REPS = LVDS_WIDTH / PATTERN_WIDTH;
  localparam int IDLE_REPS    = LVDS_WIDTH / 8;

  // ---------------- stage 1 ----------------
  logic [LVDS_WIDTH-1:0] lvds_s1_q;
  logic                  sof_s1_q;
  logic                  eof_s1_q;

  // Capture the bus and markers; no reset, contents are masked by vld_q.
  always_ff @(posedge clk) begin
    lvds_s1_q <= LVDS;
    sof_s1_q  <= SOF;
    eof_s1_q  <= EOF;
  end

  // Per-slice and per-byte compares on the stage-1 word.
  logic [PATTERN_REPS-1:0] slice_eq;
  logic [IDLE_REPS-1:0]    byte_is0;
  logic [IDLE_REPS-1:0]    byte_is1;

  for (genvar g = 0; g < PATTERN_REPS; g++) begin : g_slice
    assign slice_eq[g] = (lvds_s1_q[g*PATTERN_WIDTH +: PATTERN_WIDTH] ==
                          lvds_s1_q[PATTERN_WIDTH-1:0]);
  end

  for (genvar b = 0; b < IDLE_REPS; b++) begin : g_byte
    assign byte_is0[b] = (lvds_s1_q[b*8 +: 8] == IDLE_0);
    assign byte_is1[b] = (lvds_s1_q[b*8 +: 8] == IDLE_1);
  end

  // ---------------- stage 2 ----------------
  logic                     replica_ok_q;
  logic                     is_idle0_q;
  logic                     is_idle1_q;
  logic                     sof_s2_q;
  logic                     eof_s2_q;
  logic [PATTERN_WIDTH-1:0] slice0_s2_q;

  // Register the reduced compare results; no reset, masked by vld_q.
  always_ff @(posedge clk) begin
    replica_ok_q <= &slice_eq;
    is_idle0_q   <= &byte_is0;
    is_idle1_q   <= &byte_is1;
    sof_s2_q     <= sof_s1_q;
    eof_s2_q     <= eof_s1_q;
    slice0_s2_q  <= lvds_s1_q[PATTERN_WIDTH-1:0];
  end

  // Stage-2 contents become meaningful two cycles after reset releases.
  logic [1:0] vld_q;

  // Pipeline-valid shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[0], 1'b1};
    end
  end

  // ---------------- stage 3 ----------------
  state_e                   state_q, state_d;
  logic [31:0]              len_q, len_d;
  logic [PATTERN_WIDTH-1:0] ref_q, ref_d;
  logic                     idle_any_q, idle_any_d;
  logic                     error_q, error_d;

  logic        inc_frame, inc_idle, inc_replica, inc_length, inc_pattern, inc_proto;
  logic        tready_c;
  logic [31:0] len_inc;
  logic        want_idle1;
  logic        idle_ok;

  // FSM next state, frame bookkeeping and per-word error events.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ref_d       = ref_q;
    idle_any_d  = idle_any_q;
    inc_frame   = 1'b0;
    inc_idle    = 1'b0;
    inc_replica = 1'b0;
    inc_length  = 1'b0;
    inc_pattern = 1'b0;
    inc_proto   = 1'b0;
    tready_c    = 1'b0;
    len_inc     = (len_q == CNT_MAX) ? len_q : len_q + 32'd1;
    want_idle1  = !idle_any_q && (state_q == S_IDLE_A);
    idle_ok     = idle_any_q ? (is_idle0_q || is_idle1_q)
                             : ((state_q == S_IDLE_A) ? is_idle1_q : is_idle0_q);

    if (vld_q[1]) begin
      if (sof_s2_q && eof_s2_q) begin
        // A one-word frame is malformed: drop everything and resynchronise.
        inc_proto = 1'b1;
        state_d   = S_SYNC;
      end else if (sof_s2_q) begin
        // New frame; a SOF inside a frame abandons the old one as too short.
        inc_length  = (state_q == S_FRAME);
        state_d     = S_FRAME;
        len_d       = 32'd1;
        ref_d       = slice0_s2_q;
        inc_replica = !replica_ok_q;
        if (EXPECT_TVALID) begin
          tready_c    = 1'b1;
          inc_pattern = (slice0_s2_q != EXPECT_TDATA);
        end
      end else begin
        case (state_q)
          S_SYNC: begin
            if (eof_s2_q) begin
              inc_proto = 1'b1;
            end else if (is_idle0_q) begin
              state_d    = S_IDLE_A;
              idle_any_d = 1'b0;
            end else if (is_idle1_q) begin
              state_d    = S_IDLE_B;
              idle_any_d = 1'b0;
            end
          end
          S_IDLE_A, S_IDLE_B: begin
            if (eof_s2_q) begin
              inc_proto = 1'b1;
            end else begin
              inc_idle   = !idle_ok;
              idle_any_d = 1'b0;
              // Follow the word actually seen, preferring the expected byte
              // when IDLE_0 and IDLE_1 are programmed equal.
              if (is_idle1_q && (want_idle1 || !is_idle0_q)) begin
                state_d = S_IDLE_B;
              end else if (is_idle0_q) begin
                state_d = S_IDLE_A;
              end else begin
                state_d = S_SYNC;
              end
            end
          end
          S_FRAME: begin
            len_d       = len_inc;
            inc_replica = !replica_ok_q || (slice0_s2_q != ref_q);
            if (eof_s2_q) begin
              inc_frame  = (len_inc == CYCLES_PER_FRAME);
              inc_length = (len_inc != CYCLES_PER_FRAME);
              state_d    = S_IDLE_A;
              idle_any_d = 1'b1;
            end
          end
          default: state_d = S_SYNC;
        endcase
      end
    end

    if (CLEAR) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q | inc_idle | inc_replica | inc_length | inc_pattern | inc_proto;
    end
  end

  // FSM state, frame length/reference and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SYNC;
      len_q      <= '0;
      ref_q      <= '0;
      idle_any_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ref_q      <= ref_d;
      idle_any_q <= idle_any_d;
      error_q    <= error_d;
    end
  end

  assign EXPECT_TREADY = tready_c;
  assign ERROR         = error_q;

  sat_counter32 u_cnt_frame (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_frame), .value(FRAME_COUNT)
  );
  sat_counter32 u_cnt_idle (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_idle), .value(ERR_IDLE)
  );
  sat_counter32 u_cnt_replica (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_replica), .value(ERR_REPLICA)
  );
  sat_counter32 u_cnt_length (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_length), .value(ERR_LENGTH)
  );
  sat_counter32 u_cnt_pattern (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_pattern), .value(ERR_PATTERN)
  );
  sat_counter32 u_cnt_proto (
    .clk(clk), .reset(reset), .clear(CLEAR), .inc(inc_proto), .value(ERR_PROTO)
  );

endmodule

// File: tb/tb_sensor_frame_checker.sv
// Directed bench for sensor_frame_checker with hand-computed expectations.
module tb_sensor_frame_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         CLEAR;
  logic [31:0]  CYCLES_PER_FRAME;
  logic [7:0]   IDLE_0;
  logic [7:0]   IDLE_1;
  logic [511:0] LVDS;
  logic         SOF;
  logic         EOF;
  logic [31:0]  EXPECT_TDATA;
  logic         EXPECT_TVALID;
  logic         EXPECT_TREADY;
  logic [31:0]  FRAME_COUNT;
  logic [31:0]  ERR_IDLE;
  logic [31:0]  ERR_REPLICA;
  logic [31:0]  ERR_LENGTH;
  logic [31:0]  ERR_PATTERN;
  logic [31:0]  ERR_PROTO;
  logic         ERROR;

  int n_vec  = 0;
  int n_miss = 0;
  int ready_pulses = 0;
  logic hs_pending = 1'b0;
  logic idle_phase = 1'b0;
  logic [31:0] exp_q[$];

  sensor_frame_checker #(.PATTERN_WIDTH(32), .LVDS_WIDTH(512)) dut (
    .clk(clk), .reset(reset), .CLEAR(CLEAR), .CYCLES_PER_FRAME(CYCLES_PER_FRAME),
    .IDLE_0(IDLE_0), .IDLE_1(IDLE_1), .LVDS(LVDS), .SOF(SOF), .EOF(EOF),
    .EXPECT_TDATA(EXPECT_TDATA), .EXPECT_TVALID(EXPECT_TVALID),
    .EXPECT_TREADY(EXPECT_TREADY), .FRAME_COUNT(FRAME_COUNT), .ERR_IDLE(ERR_IDLE),
    .ERR_REPLICA(ERR_REPLICA), .ERR_LENGTH(ERR_LENGTH), .ERR_PATTERN(ERR_PATTERN),
    .ERR_PROTO(ERR_PROTO), .ERROR(ERROR)
  );

  // Clock.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // Expected-pattern stream source: offers the head of exp_q, pops on handshake.
  initial begin
    EXPECT_TVALID = 1'b0;
    EXPECT_TDATA  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pending && (exp_q.size() > 0)) void'(exp_q.pop_front());
      hs_pending    = 1'b0;
      EXPECT_TVALID = (exp_q.size() > 0);
      EXPECT_TDATA  = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      @(negedge clk);
      if (EXPECT_TVALID && EXPECT_TREADY) begin
        hs_pending   = 1'b1;
        ready_pulses = ready_pulses + 1;
      end
    end
  end

  function automatic logic [511:0] pat_word(input logic [31:0] p);
    return {16{p}};
  endfunction

  function automatic logic [511:0] idle_word(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] fc, input logic [31:0] ei,
                               input logic [31:0] er, input logic [31:0] el,
                               input logic [31:0] ep, input logic [31:0] epr, input logic err);
    check_val({tag, "_frames"},  FRAME_COUNT, fc);
    check_val({tag, "_idle"},    ERR_IDLE,    ei);
    check_val({tag, "_replica"}, ERR_REPLICA, er);
    check_val({tag, "_length"},  ERR_LENGTH,  el);
    check_val({tag, "_pattern"}, ERR_PATTERN, ep);
    check_val({tag, "_proto"},   ERR_PROTO,   epr);
    check_val({tag, "_error"},   {31'd0, ERROR}, {31'd0, err});
  endtask

  // Present one bus word for one cycle (changed on the falling edge).
  task automatic drive_word(input logic [511:0] w, input logic sof, input logic eof);
    @(negedge clk);
    LVDS = w;
    SOF  = sof;
    EOF  = eof;
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_word(idle_word(idle_phase ? 8'h5A : 8'hA5), 1'b0, 1'b0);
      idle_phase = ~idle_phase;
    end
  endtask

  task automatic send_frame(input logic [31:0] p, input int len);
    for (int i = 0; i < len; i++) drive_word(pat_word(p), (i == 0), (i == len - 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    CLEAR = 1'b0;
    LVDS  = '0;
    SOF   = 1'b0;
    EOF   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b0;
    idle_phase   = 1'b0;
    ready_pulses = 0;
  endtask

  initial begin
    logic [511:0] w;
    reset = 1'b1; CLEAR = 1'b0; CYCLES_PER_FRAME = 32'd8;
    IDLE_0 = 8'hA5; IDLE_1 = 8'h5A; LVDS = '0; SOF = 1'b0; EOF = 1'b0;

    // Reset state.
    do_reset();
    check_outputs("rst", 0, 0, 0, 0, 0, 0, 1'b0);
    check_val("rst_tready", {31'd0, EXPECT_TREADY}, 32'd0);

    // Clean traffic: 10 idles, three 8-cycle frames matching the stream.
    exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h3);
    send_idles(10);
    send_frame(32'h1, 8);
    send_frame(32'h2, 8);
    send_frame(32'h3, 8);
    send_idles(4);
    check_outputs("good", 3, 0, 0, 0, 0, 0, 1'b0);
    check_val("good_tready_pulses", ready_pulses, 32'd3);

    // Short frame, then a frame truncated by SOF at its 5th cycle.
    do_reset();
    send_idles(4);
    send_frame(32'h4, 7);
    send_idles(2);
    check_val("len_err_early", {31'd0, ERROR}, 32'd0);
    send_idles(1);
    check_val("len_err_at3", {31'd0, ERROR}, 32'd1);
    check_val("len_short_cnt", ERR_LENGTH, 32'd1);
    for (int i = 0; i < 4; i++) drive_word(pat_word(32'h5), (i == 0), 1'b0);
    for (int i = 0; i < 4; i++) drive_word(pat_word(32'h6), (i == 0), 1'b0);
    check_outputs("len_trunc", 0, 0, 0, 2, 0, 0, 1'b1);

    // Replica corruption, pattern mismatch, mid-frame pattern change.
    do_reset();
    exp_q.push_back(32'hCAFE_0001); exp_q.push_back(32'hDEAD_BEEE);
    send_idles(2);
    for (int i = 0; i < 8; i++) begin
      w = pat_word(32'hCAFE_0001);
      if (i == 3) w[511:480] = w[511:480] ^ 32'h1;
      drive_word(w, (i == 0), (i == 7));
    end
    send_idles(4);
    check_outputs("rep1", 1, 0, 1, 0, 0, 0, 1'b1);
    send_frame(32'hDEAD_BEEF, 8);
    send_idles(4);
    check_outputs("pat", 2, 0, 1, 0, 1, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      drive_word(pat_word((i == 2) ? 32'h8 : 32'h7), (i == 0), (i == 7));
    send_idles(4);
    check_outputs("rep2", 3, 0, 2, 0, 1, 0, 1'b1);
    check_val("rep2_tready_pulses", ready_pulses, 32'd2);

    // Idle alternation errors.
    do_reset();
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h00), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    check_outputs("idle", 0, 2, 0, 0, 0, 0, 1'b1);

    // Protocol errors, then CLEAR coinciding with a third one.
    do_reset();
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b1);
    drive_word(pat_word(32'h9), 1'b1, 1'b1);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    check_outputs("proto", 0, 0, 0, 0, 0, 2, 1'b1);
    drive_word(idle_word(8'h5A), 1'b0, 1'b1);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    CLEAR = 1'b1;
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    CLEAR = 1'b0;
    check_outputs("clear", 0, 0, 0, 0, 0, 0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    check_outputs("clear_after", 0, 0, 0, 0, 0, 0, 1'b0);

    // Saturation of ERR_IDLE.
    do_reset();
    force dut.u_cnt_idle.count_q = 32'hFFFF_FFFE;
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    #1;
    release dut.u_cnt_idle.count_q;
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    drive_word(idle_word(8'hA5), 1'b0, 1'b0);
    drive_word(idle_word(8'h5A), 1'b0, 1'b0);
    check_val("sat_idle", ERR_IDLE, 32'hFFFF_FFFF);
    check_val("sat_error", {31'd0, ERROR}, 32'd1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 3; i++) drive_word(pat_word(32'hB), (i == 0), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("midrst", 0, 0, 0, 0, 0, 0, 1'b0);
    check_val("midrst_tready", {31'd0, EXPECT_TREADY}, 32'd0);
    reset = 1'b0;
    send_frame(32'hC, 8);
    send_idles(4);
    check_outputs("post_rst", 1, 0, 0, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
